ov7670_stream_gen: RTL and testbench
====================================

# ov7670_stream_gen

Generates an OV7670-compatible parallel pixel stream: pclk, vsync, href and 8-bit data. The pixels come either from a frame buffer read port or from an internal test pattern. It is the transmit end of the camera interface that ov7670_capture receives. It lets the capture → frame_buffer → edge_proc → vga_display chain run in simulation and on boards without a camera, by driving capture's pclk/vsync/href/data inputs directly. The image size matches the 80x60 gray (YUV) / RGB444 capture configuration.

## Interface
- c_img_cols, 80, active pixels per line
- c_img_rows, 60, active lines per frame
- c_nb_img_pxls, 13, pixel address width
- c_pclk_half, 2, clk cycles per pclk half-period (≥2)
- c_vsync_lines, 3, line periods with vsync high
- c_vbp_lines, 2, blank line periods after vsync, before first active line
- c_vfp_lines, 2, blank line periods after last active line
- c_hblank, 16, pclk periods per line with href low
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  reset; asynchronous, active-low
- gen_en  in  1  frame generation enable
- rgbmode  in  1  0: YUV422 (gray source), 1: RGB444
- pattern_sel  in  1  0: pixels from frame buffer, 1: internal pattern
- pxl_addr  out  c_nb_img_pxls  frame buffer read address
- pxl_in  in  12  frame buffer data; 1-clk read latency; gray uses [7:0], RGB444 is {R,G,B}
- pclk  out  1  pixel clock
- vsync  out  1  frame sync, active-high
- href  out  1  line valid, active-high
- d  out  8  pixel byte
- frame_cnt  out  8  completed frames, wraps 255→0
- busy  out  1  high from frame start to end of VFP

## Operation
- Free-running pclk divider. pclk toggles every c_pclk_half clk cycles while rst_n is high.
- All stream outputs (vsync, href, d) update only in the clk cycle where pclk goes 1→0. The receiver samples on pclk rising edges.
- Line period L = 2*c_img_cols + c_hblank pclk periods (default 176). Every line period, active or blank, has length L.
- Within an active line, href is high for the first 2*c_img_cols pclk periods, then low for c_hblank.
- FSM states:
  - IDLE → VSYNC on a falling pclk edge with gen_en=1.
  - VSYNC (c_vsync_lines periods, vsync=1, href=0) → VBP.
  - VBP (c_vbp_lines, both low) → ACTIVE.
  - ACTIVE (c_img_rows lines) → VFP.
  - VFP (c_vfp_lines) → at end: frame_cnt++; if gen_en=1 go to VSYNC, else go to IDLE.
- gen_en low mid-frame does not abort; the current frame completes.
- Byte order per pixel, two bytes:
  - YUV: first Y, second 0x80.
  - RGB444: first {4'h0,R}, second {G,B}.
- Y source: pxl_in[7:0], or pattern.
  - Gray pattern: Y = (col + row) mod 256.
  - RGB pattern: {R,G,B} = {col[3:0], row[3:0], 4'hF}.
- pxl_addr = row*c_img_cols + col. Drive it at least 2 clk before the falling edge that emits the pixel's first byte.
- Latch the pixel into a 12-bit register. Both bytes come from that register, so a pxl_in change mid-pixel has no effect.
- rgbmode and pattern_sel are sampled at frame start (entry to VSYNC) and held for the frame.
- Counters:
  - col 0..c_img_cols-1
  - row 0..c_img_rows-1
  - byte/pclk counter within the line 0..L-1
  - line counter within the current state

## Timing
- Reset values: pclk=0, vsync=0, href=0, d=0x00, pxl_addr=0, frame_cnt=0, busy=0, state IDLE, divider 0.
- Reset is asynchronous. Mid-frame assertion returns everything to reset values immediately, with no partial-line completion.
- pclk period = 2*c_pclk_half clk (default 4 clk, 25 MHz).
- Frame = (c_vsync_lines + c_vbp_lines + c_img_rows + c_vfp_lines)*L pclk periods. Default: 67*176 = 11792 pclk = 47168 clk.
- First falling edge after gen_en rises: vsync=1, busy=1.
- href rises on the first falling edge of the first ACTIVE line. On that same edge, d = first byte of pixel (0,0).
- d is stable for one full pclk period, and is never changed while pclk is high.
- When href=0, d=0x00.
- frame_cnt increments on the falling edge that ends the last VFP line. busy drops on that same edge if returning to IDLE.
- pxl_addr wraps only at frame start (back to 0). The maximum is c_img_cols*c_img_rows-1 = 4799.

## Test plan
- Reset/idle: hold rst_n=0, then release with gen_en=0 for 1000 clk. Outputs stay at reset values; pclk toggles every 2 clk.
- Frame timing, pattern_sel=1, rgbmode=0, gen_en=1:
  - vsync high for exactly 528 pclk;
  - 60 href pulses of 160 pclk, each followed by 16 low;
  - frame length 11792 pclk;
  - frame_cnt 0→1.
- Pattern data, YUV: bytes at row 3, col 5 are 0x08, 0x80. Bytes at row 59, col 79 are 0x8A, 0x80. Check with a rising-edge sampler.
- Frame buffer path: behavioural 1-clk-latency RAM with pxl_in = {4'h0, addr[7:0]}.
  - Each pixel's Y byte equals the low 8 bits of row*80+col.
  - The last address issued is 4799.
- RGB444: pattern, row 2, col 7 emits 0x07 then 0x2F. rgbmode toggled mid-frame has no effect until the next frame.
- Stop/restart and reset:
  - gen_en dropped at line 20: the frame completes, then IDLE with busy=0.
  - rst_n asserted mid-line: vsync, href and d go to 0 within the same clk; frame_cnt returns to 0.

Source files
------------

// File: rtl/ov7670_stream_gen_if.sv
// Parallel camera bus as seen by an OV7670 receiver: pixel clock, frame/line syncs and data byte.
interface ov7670_stream_gen_if;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] d;

  modport master (output pclk, output vsync, output href, output d);
  modport slave  (input  pclk, input  vsync, input  href, input  d);
endinterface

// File: rtl/ov7670_stream_gen.sv
// OV7670-compatible stream source: emits vsync/href/data frames from a frame buffer or a test pattern.
// Stream outputs change only on the clk cycle in which pclk falls, so the receiver samples on pclk rise.
module ov7670_stream_gen #(
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_nb_img_pxls = 13,
  parameter int c_pclk_half   = 2,
  parameter int c_vsync_lines = 3,
  parameter int c_vbp_lines   = 2,
  parameter int c_vfp_lines   = 2,
  parameter int c_hblank      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     gen_en,
  input  logic                     rgbmode,
  input  logic                     pattern_sel,
  output logic [c_nb_img_pxls-1:0] pxl_addr,
  input  logic [11:0]              pxl_in,
  ov7670_stream_gen_if.master      cam,
  output logic [7:0]               frame_cnt,
  output logic                     busy
);

  localparam int c_act_len  = 2 * c_img_cols;
  localparam int c_line_len = c_act_len + c_hblank;
  localparam int c_div_w    = $clog2(c_pclk_half + 1);
  localparam int c_pos_w    = $clog2(c_line_len + 1);
  localparam int c_line_w   = $clog2(c_img_rows + c_vsync_lines + c_vbp_lines + c_vfp_lines + 1);
  localparam int c_col_w    = $clog2(c_img_cols + 1);
  localparam int c_row_w    = $clog2(c_img_rows + 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t                   state_reg, state_next;
  logic [c_div_w-1:0]       div_reg;
  logic                     pclk_reg;
  logic [c_pos_w-1:0]       pos_reg, pos_next;
  logic [c_line_w-1:0]      line_reg, line_next, last_line;
  logic [c_col_w-1:0]       col_reg, col_next;
  logic [c_row_w-1:0]       row_reg, row_next;
  logic [c_nb_img_pxls-1:0] addr_reg, addr_next;
  logic [11:0]              px_reg, px_next, fetch;
  logic                     vsync_reg, vsync_next;
  logic                     href_reg, href_next;
  logic [7:0]               d_reg, d_next;
  logic                     busy_reg, busy_next;
  logic [7:0]               frame_cnt_reg, frame_cnt_next;
  logic                     rgb_reg, rgb_next;
  logic                     pat_reg, pat_next;
  logic                     pclk_edge, fall, rise, start, emit_first;
  logic [7:0]               col8, row8, byte0, byte1;

  // Free-running divider; pclk starts low and toggles every c_pclk_half clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg  <= '0;
      pclk_reg <= 1'b0;
    end else if (pclk_edge) begin
      div_reg  <= '0;
      pclk_reg <= ~pclk_reg;
    end else begin
      div_reg  <= div_reg + 1'b1;
    end
  end

  assign pclk_edge = (div_reg == c_div_w'(c_pclk_half - 1));
  assign fall      = pclk_edge & pclk_reg;
  assign rise      = pclk_edge & ~pclk_reg;

  always_comb begin
    last_line = c_line_w'(c_vfp_lines - 1);
    case (state_reg)
      VSYNC:   last_line = c_line_w'(c_vsync_lines - 1);
      VBP:     last_line = c_line_w'(c_vbp_lines - 1);
      ACTIVE:  last_line = c_line_w'(c_img_rows - 1);
      default: last_line = c_line_w'(c_vfp_lines - 1);
    endcase
  end

  always_comb begin
    col8  = 8'(col_reg);
    row8  = 8'(row_reg);
    fetch = pxl_in;
    if (pat_reg) begin
      fetch = rgb_reg ? {col8[3:0], row8[3:0], 4'hF} : {4'h0, col8 + row8};
    end
    byte0 = rgb_reg ? {4'h0, px_reg[11:8]} : px_reg[7:0];
    byte1 = rgb_reg ? px_reg[7:0] : 8'h80;
  end

  always_comb begin
    state_next     = state_reg;
    pos_next       = pos_reg;
    line_next      = line_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    addr_next      = addr_reg;
    px_next        = px_reg;
    vsync_next     = vsync_reg;
    href_next      = href_reg;
    d_next         = d_reg;
    busy_next      = busy_reg;
    frame_cnt_next = frame_cnt_reg;
    rgb_next       = rgb_reg;
    pat_next       = pat_reg;
    start          = 1'b0;
    emit_first     = (state_reg == ACTIVE) && href_reg && !pos_reg[0];

    // The pixel register is frozen while its first byte is on the bus, so both bytes share one sample.
    if (rise && !emit_first) begin
      px_next = fetch;
    end

    if (fall) begin
      case (state_reg)
        IDLE: start = gen_en;
        default: begin
          if (pos_reg != c_pos_w'(c_line_len - 1)) begin
            pos_next = pos_reg + 1'b1;
          end else begin
            pos_next = '0;
            if (line_reg != last_line) begin
              line_next = line_reg + 1'b1;
            end else begin
              line_next = '0;
              case (state_reg)
                VSYNC:  state_next = VBP;
                VBP:    state_next = ACTIVE;
                ACTIVE: state_next = VFP;
                default: begin
                  frame_cnt_next = frame_cnt_reg + 1'b1;
                  if (gen_en) start = 1'b1;
                  else        state_next = IDLE;
                end
              endcase
            end
          end
        end
      endcase

      if (start) begin
        state_next = VSYNC;
        pos_next   = '0;
        line_next  = '0;
        rgb_next   = rgbmode;
        pat_next   = pattern_sel;
        addr_next  = '0;
        col_next   = '0;
        row_next   = '0;
      end

      vsync_next = (state_next == VSYNC);
      busy_next  = (state_next != IDLE);
      href_next  = (state_next == ACTIVE) && (pos_next < c_pos_w'(c_act_len));
      d_next     = href_next ? (pos_next[0] ? byte1 : byte0) : 8'h00;

      // Step the read address once the second byte goes out, giving a full pclk period of lead time.
      if (href_next && pos_next[0]) begin
        if (col_reg != c_col_w'(c_img_cols - 1)) begin
          col_next  = col_reg + 1'b1;
          addr_next = addr_reg + 1'b1;
        end else if (row_reg != c_row_w'(c_img_rows - 1)) begin
          col_next  = '0;
          row_next  = row_reg + 1'b1;
          addr_next = addr_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pos_reg       <= '0;
      line_reg      <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      addr_reg      <= '0;
      px_reg        <= '0;
      vsync_reg     <= 1'b0;
      href_reg      <= 1'b0;
      d_reg         <= 8'h00;
      busy_reg      <= 1'b0;
      frame_cnt_reg <= 8'h00;
      rgb_reg       <= 1'b0;
      pat_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pos_reg       <= pos_next;
      line_reg      <= line_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      addr_reg      <= addr_next;
      px_reg        <= px_next;
      vsync_reg     <= vsync_next;
      href_reg      <= href_next;
      d_reg         <= d_next;
      busy_reg      <= busy_next;
      frame_cnt_reg <= frame_cnt_next;
      rgb_reg       <= rgb_next;
      pat_reg       <= pat_next;
    end
  end

  assign cam.pclk  = pclk_reg;
  assign cam.vsync = vsync_reg;
  assign cam.href  = href_reg;
  assign cam.d     = d_reg;
  assign pxl_addr  = addr_reg;
  assign frame_cnt = frame_cnt_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen on a reduced image size: pixel probe table, whole-frame model compare,
// random frame-buffer data and modes, stop/restart and asynchronous reset.
module tb_ov7670_stream_gen;
  localparam int C = 16, R = 8, NB = 13, H = 2, VS = 3, VBP = 2, VFP = 2, HB = 6;
  localparam int L = 2 * C + HB;
  localparam int NLINES = VS + VBP + R + VFP;
  localparam int F = NLINES * L;
  localparam int AW = $clog2(C * R);
  localparam int NV = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          gen_en = 1'b0;
  logic          rgbmode = 1'b0;
  logic          pattern_sel = 1'b0;
  logic [NB-1:0] pxl_addr;
  logic [11:0]   pxl_in;
  logic [7:0]    frame_cnt;
  logic          busy;

  ov7670_stream_gen_if cam ();

  ov7670_stream_gen #(
    .c_img_cols(C), .c_img_rows(R), .c_nb_img_pxls(NB), .c_pclk_half(H),
    .c_vsync_lines(VS), .c_vbp_lines(VBP), .c_vfp_lines(VFP), .c_hblank(HB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gen_en(gen_en), .rgbmode(rgbmode), .pattern_sel(pattern_sel),
    .pxl_addr(pxl_addr), .pxl_in(pxl_in), .cam(cam), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Frame buffer with one clk of read latency.
  logic [11:0] mem [C*R];
  bit          use_rand = 1'b0;
  always @(posedge clk) pxl_in <= use_rand ? mem[pxl_addr[AW-1:0]] : {4'h0, pxl_addr[7:0]};

  int checks = 0;
  int passes = 0;
  int frames_done = 0;

  logic       s_vs [F];
  logic       s_hr [F];
  logic [7:0] s_d  [F];
  bit         carry = 1'b0;
  logic       c_vs, c_hr;
  logic [7:0] c_d;

  typedef struct {
    bit         rgb;
    bit         pat;
    int         row;
    int         col;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;
  vec_t vecs [NV];

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic logic [7:0] pix_byte(input bit rgb, pat, rnd, input int row, col, bsel);
    logic [11:0] px;
    int a;
    a = row * C + col;
    if (pat) px = rgb ? {col[3:0], row[3:0], 4'hF} : {4'h0, 8'(col + row)};
    else if (rnd) px = mem[a];
    else px = {4'h0, 8'(a)};
    if (rgb) return (bsel == 0) ? {4'h0, px[11:8]} : px[7:0];
    return (bsel == 0) ? px[7:0] : 8'h80;
  endfunction

  // Expected bus state during pclk period i of a frame, counted from the vsync leading edge.
  task automatic expect_at(input int i, input bit rgb, pat, rnd,
                           output logic evs, output logic ehr, output logic [7:0] ed);
    int ln, p;
    ln  = i / L;
    p   = i % L;
    evs = (ln < VS);
    ehr = (ln >= VS + VBP) && (ln < VS + VBP + R) && (p < 2 * C);
    ed  = ehr ? pix_byte(rgb, pat, rnd, ln - VS - VBP, p / 2, p % 2) : 8'h00;
  endtask

  task automatic sample(output logic vs, output logic hr, output logic [7:0] dd);
    @(posedge cam.pclk);
    #1;
    vs = cam.vsync;
    hr = cam.href;
    dd = cam.d;
  endtask

  task automatic run_frame(input bit f_rgb, f_pat, f_rnd, input bit n_rgb, n_pat, n_gen, input string tag);
    logic vs, hr, pv, evs, ehr;
    logic [7:0] dd, ed;
    logic [NB-1:0] last_addr;
    bit found;
    int bad, vs_hi, pulses, bad_len, run;
    string det;
    found = 1'b0;
    if (carry) begin
      s_vs[0] = c_vs; s_hr[0] = c_hr; s_d[0] = c_d;
      found = 1'b1;
    end else begin
      pv = 1'b0;
      for (int k = 0; k < 4 * F && !found; k++) begin
        sample(vs, hr, dd);
        if (!pv && vs === 1'b1) found = 1'b1;
        pv = vs;
      end
      s_vs[0] = vs; s_hr[0] = hr; s_d[0] = dd;
    end
    check(found, {tag, "_start"}, "got no vsync rise, want one within the wait window");
    carry = 1'b0;
    if (!found) return;
    last_addr = '0;
    for (int i = 1; i < F; i++) begin
      if (i == F / 2) begin
        rgbmode = n_rgb; pattern_sel = n_pat; gen_en = n_gen;
      end
      sample(s_vs[i], s_hr[i], s_d[i]);
      if (i == F - 1) last_addr = pxl_addr;
    end
    sample(vs, hr, dd);
    frames_done++;
    if (n_gen) begin
      check(vs === 1'b1 && s_vs[F-1] === 1'b0, {tag, "_frame_len"},
            $sformatf("got vsync %b->%b at period %0d, want 0->1", s_vs[F-1], vs, F));
      carry = (vs === 1'b1);
      c_vs = vs; c_hr = hr; c_d = dd;
    end else begin
      check(vs === 1'b0 && busy === 1'b0, {tag, "_stop"},
            $sformatf("got vsync=%b busy=%b after frame, want 0 0", vs, busy));
    end
    check(frame_cnt === 8'(frames_done), {tag, "_frame_cnt"},
          $sformatf("got %0d, want %0d", frame_cnt, frames_done));
    if (!f_pat)
      check(int'(last_addr) == C * R - 1, {tag, "_last_addr"},
            $sformatf("got %0d, want %0d", last_addr, C * R - 1));
    bad = 0; det = "";
    for (int i = 0; i < F; i++) begin
      expect_at(i, f_rgb, f_pat, f_rnd, evs, ehr, ed);
      if (s_vs[i] !== evs || s_hr[i] !== ehr || s_d[i] !== ed) begin
        if (bad == 0)
          det = $sformatf("period %0d got vs=%b href=%b d=%02h want vs=%b href=%b d=%02h",
                          i, s_vs[i], s_hr[i], s_d[i], evs, ehr, ed);
        bad++;
      end
    end
    check(bad == 0, {tag, "_stream"}, $sformatf("%0d bad periods, first: %s", bad, det));
    vs_hi = 0; pulses = 0; bad_len = 0; run = 0;
    for (int i = 0; i < F; i++) begin
      if (s_vs[i] === 1'b1) vs_hi++;
      if (s_hr[i] === 1'b1) run++;
      else if (run > 0) begin
        pulses++;
        if (run != 2 * C) bad_len++;
        run = 0;
      end
    end
    if (run > 0) begin pulses++; bad_len++; end
    check(vs_hi == VS * L, {tag, "_vsync_len"}, $sformatf("got %0d pclk, want %0d", vs_hi, VS * L));
    check(pulses == R && bad_len == 0, {tag, "_href"},
          $sformatf("got %0d pulses (%0d wrong length), want %0d of %0d", pulses, bad_len, R, 2 * C));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pp;
    int run, toggles, bad_pclk, bad_idle, i0, nv;
    bit found, nr, np, cur_rgb, cur_pat;

    vecs[0] = '{0, 1, 3, 5, 8'h08, 8'h80};
    vecs[1] = '{0, 1, 7, 15, 8'h16, 8'h80};
    vecs[2] = '{1, 1, 2, 7, 8'h07, 8'h2F};
    vecs[3] = '{1, 1, 7, 15, 8'h0F, 8'h7F};
    vecs[4] = '{0, 0, 3, 5, 8'h35, 8'h80};
    vecs[5] = '{1, 0, 7, 15, 8'h00, 8'h7F};
    vecs[6] = '{0, 0, 7, 15, 8'h7F, 8'h80};

    // Reset values while held in reset.
    repeat (5) @(negedge clk);
    check(cam.pclk === 1'b0 && cam.vsync === 1'b0 && cam.href === 1'b0 && cam.d === 8'h00 &&
          pxl_addr === '0 && frame_cnt === 8'h00 && busy === 1'b0, "reset_vals",
          $sformatf("got pclk=%b vs=%b href=%b d=%02h addr=%0d cnt=%0d busy=%b, want all 0",
                    cam.pclk, cam.vsync, cam.href, cam.d, pxl_addr, frame_cnt, busy));

    // Idle with generation disabled: only pclk moves.
    rst_n = 1'b1;
    pp = cam.pclk; run = 0; toggles = 0; bad_pclk = 0; bad_idle = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (cam.pclk !== pp) begin
        if (toggles > 0 && run != H) bad_pclk++;
        toggles++; run = 1; pp = cam.pclk;
      end else run++;
      if (cam.vsync !== 1'b0 || cam.href !== 1'b0 || cam.d !== 8'h00 || busy !== 1'b0 ||
          frame_cnt !== 8'h00 || pxl_addr !== '0) bad_idle++;
    end
    check(bad_pclk == 0 && toggles >= 1000 / H - 2, "pclk_div",
          $sformatf("got %0d toggles, %0d wrong half-periods, want ~%0d toggles of %0d clk", toggles, bad_pclk, 1000 / H, H));
    check(bad_idle == 0, "idle_outputs", $sformatf("got %0d cycles with active outputs, want 0", bad_idle));

    // First falling pclk edge after enable opens the frame.
    rgbmode = vecs[0].rgb; pattern_sel = vecs[0].pat; gen_en = 1'b1;
    found = 1'b0; pp = cam.pclk;
    for (int k = 0; k < 4 * H + 2 && !found; k++) begin
      @(negedge clk);
      if (pp === 1'b1 && cam.pclk === 1'b0) found = 1'b1;
      pp = cam.pclk;
    end
    check(found && cam.vsync === 1'b1 && busy === 1'b1, "start_edge",
          $sformatf("got fall=%b vsync=%b busy=%b, want 1 1 1", found, cam.vsync, busy));

    // Table of probe pixels, one frame per vector, next mode applied mid-frame.
    for (int v = 0; v < NV; v++) begin
      nv = (v + 1 < NV) ? v + 1 : v;
      run_frame(vecs[v].rgb, vecs[v].pat, 1'b0,
                (v + 1 < NV) ? vecs[nv].rgb : ~vecs[v].rgb, vecs[nv].pat, v + 1 < NV,
                $sformatf("vec%0d", v));
      i0 = (VS + VBP + vecs[v].row) * L + 2 * vecs[v].col;
      check(s_d[i0] === vecs[v].b0 && s_d[i0+1] === vecs[v].b1, $sformatf("probe%0d", v),
            $sformatf("got %02h %02h, want %02h %02h", s_d[i0], s_d[i0+1], vecs[v].b0, vecs[v].b1));
    end

    // Stopped generator stays idle.
    bad_idle = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cam.vsync !== 1'b0 || cam.href !== 1'b0 || busy !== 1'b0) bad_idle++;
    end
    check(bad_idle == 0, "idle_after_stop", $sformatf("got %0d active cycles, want 0", bad_idle));

    // Random frame-buffer contents and random per-frame modes.
    foreach (mem[k]) mem[k] = 12'($urandom);
    use_rand = 1'b1;
    cur_rgb = 1'($urandom); cur_pat = 1'b0;
    rgbmode = cur_rgb; pattern_sel = cur_pat; gen_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      nr = 1'($urandom); np = 1'($urandom);
      run_frame(cur_rgb, cur_pat, 1'b1, nr, np, f < 2, $sformatf("rnd%0d", f));
      cur_rgb = nr; cur_pat = np;
    end

    // Asynchronous reset in the middle of an active line.
    gen_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 3 * F * 2 * H && !found; k++) begin
      @(negedge clk);
      if (cam.href === 1'b1) found = 1'b1;
    end
    check(found, "href_before_reset", "got no href, want an active line");
    repeat ($urandom_range(0, 6)) @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(cam.vsync === 1'b0 && cam.href === 1'b0 && cam.d === 8'h00, "async_reset_bus",
          $sformatf("got vs=%b href=%b d=%02h, want 0 0 00", cam.vsync, cam.href, cam.d));
    check(frame_cnt === 8'h00 && busy === 1'b0, "async_reset_cnt",
          $sformatf("got frame_cnt=%0d busy=%b, want 0 0", frame_cnt, busy));
    check(cam.pclk === 1'b0 && pxl_addr === '0, "async_reset_misc",
          $sformatf("got pclk=%b addr=%0d, want 0 0", cam.pclk, pxl_addr));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
